// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (I) and
//               data access (D).
//
//               - When both sides request, the grant alternates between
//                 them (round-robin).
//               - The address and write data are latched at grant.
//               - A registered one-cycle valid pulse returns the read data.
//               - A busy-cycle watchdog abandons an access that is never
//                 acknowledged and sets a sticky Err flag.
// Ports       : clk, reset             - clock, synchronous active-high reset
//               IReq/IAddr             - fetch request and address
//               DReq/DWe/DAddr/DWData  - data request, store flag, addr, data
//               MemReq/MemWe/MemAddr/MemWData/MemRData/MemAck - shared port
//               IData/IValid, DData/DValid - returned data and valid pulses
//               StallF, StallM         - pipeline stalls
//               Err                    - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemAck,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic [DW-1:0] IData,
  output logic          IValid,
  output logic [DW-1:0] DData,
  output logic          DValid,
  output logic          StallF,
  output logic          StallM,
  output logic          Err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  // The watchdog fires in the TIMEOUT-th busy cycle that has no acknowledge.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q,     state_d;
  logic          last_d_q,    last_d_d;     // 1: most recent grant went to D
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] idata_q,     idata_d;
  logic [DW-1:0] ddata_q,     ddata_d;
  logic          ivalid_q,    ivalid_d;
  logic          dvalid_q,    dvalid_d;
  logic          err_q,       err_d;

  logic          elig_i, elig_d, timeout, done;
  logic [DW-1:0] ret_data;

  // A request that is still high in its own valid-pulse cycle is the
  // request that was just served. It is therefore not eligible for a grant.
  assign elig_i   = IReq & ~ivalid_q;
  assign elig_d   = DReq & ~dvalid_q;
  assign timeout  = (cnt_q == CNT_LAST);
  assign done     = MemAck | timeout;
  // An acknowledge has priority over a watchdog expiry in the same cycle.
  // A timed-out access returns zero data.
  assign ret_data = MemAck ? MemRData : '0;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    idata_d     = idata_q;
    ddata_d     = ddata_q;
    ivalid_d    = 1'b0;
    dvalid_d    = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (elig_i && (!elig_d || last_d_q)) begin
          state_d    = IBUSY;
          mem_addr_d = IAddr;
          mem_we_d   = 1'b0;
          cnt_d      = '0;
        end else if (elig_d) begin
          state_d     = DBUSY;
          mem_addr_d  = DAddr;
          mem_wdata_d = DWData;
          mem_we_d    = DWe;
          cnt_d       = '0;
        end
      end

      IBUSY, DBUSY: begin
        if (done) begin
          state_d  = IDLE;
          mem_we_d = 1'b0;
          last_d_d = (state_q == DBUSY);
          err_d    = err_q | ~MemAck;
          if (state_q == IBUSY) begin
            ivalid_d = 1'b1;
            idata_d  = ret_data;
          end else begin
            dvalid_d = 1'b1;
            // A completed store leaves DData untouched.
            if (!(MemAck && mem_we_q)) begin
              ddata_d = ret_data;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      idata_q     <= '0;
      ddata_q     <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      idata_q     <= idata_d;
      ddata_q     <= ddata_d;
      ivalid_q    <= ivalid_d;
      dvalid_q    <= dvalid_d;
      err_q       <= err_d;
    end
  end

  assign MemReq   = (state_q != IDLE);
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign IData    = idata_q;
  assign IValid   = ivalid_q;
  assign DData    = ddata_q;
  assign DValid   = dvalid_q;
  assign Err      = err_q;
  assign StallF   = IReq & ~ivalid_q;
  assign StallM   = DReq & ~dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter.
//               - Directed scenarios pin literal values.
//               - Randomized requesters and memory run afterwards.
//               - A transaction-level reference model predicts every output
//                 on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          IReq, DReq, DWe, MemAck;
  logic [AW-1:0] IAddr, DAddr;
  logic [DW-1:0] DWData, MemRData;
  logic          MemReq, MemWe, IValid, DValid, StallF, StallM, Err;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData, IData, DData;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .IData(IData), .IValid(IValid), .DData(DData), .DValid(DValid),
    .StallF(StallF), .StallM(StallM), .Err(Err)
  );

  int checks = 0;
  int errors = 0;
  bit done   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model, kept at the transaction level.
  //   m_owner   : who holds the port (0 none, 1 fetch, 2 data)
  //   m_elapsed : busy cycles spent on the current access
  // --------------------------------------------------------------------------
  int          m_owner = 0;
  int          m_elapsed = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_idata = 0, m_ddata = 0;
  bit          m_we = 0, m_last_was_d = 1, m_iv = 0, m_dv = 0, m_err = 0;

  task automatic model_step();
    bit          iv_n, dv_n, want_i, want_d;
    int          pick;
    logic [31:0] data;
    iv_n = 0;
    dv_n = 0;
    if (reset) begin
      m_owner = 0; m_elapsed = 0; m_addr = 0; m_wdata = 0;
      m_idata = 0; m_ddata = 0; m_we = 0; m_err = 0; m_last_was_d = 1;
    end else if (m_owner == 0) begin
      want_i = IReq && !m_iv;
      want_d = DReq && !m_dv;
      if (want_i && want_d) pick = m_last_was_d ? 1 : 2;
      else if (want_i)      pick = 1;
      else if (want_d)      pick = 2;
      else                  pick = 0;
      if (pick == 1) begin
        m_owner = 1; m_elapsed = 0; m_addr = IAddr; m_we = 0;
      end else if (pick == 2) begin
        m_owner = 2; m_elapsed = 0; m_addr = DAddr; m_wdata = DWData; m_we = DWe;
      end
    end else begin
      m_elapsed++;
      if (MemAck || m_elapsed == TO) begin
        data = MemAck ? MemRData : 32'h0;
        if (m_owner == 1) begin
          m_idata = data;
          iv_n = 1;
        end else begin
          if (!(MemAck && m_we)) m_ddata = data;
          dv_n = 1;
        end
        if (!MemAck) m_err = 1;
        m_last_was_d = (m_owner == 2);
        m_owner = 0;
        m_we = 0;
      end
    end
    m_iv = iv_n;
    m_dv = dv_n;
  endtask

  task automatic model_compare();
    chk("MemReq", MemReq, m_owner != 0);
    if (m_owner != 0) begin
      chk("MemAddr", MemAddr, m_addr);
      chk("MemWe", MemWe, m_we);
      if (m_owner == 2 && m_we) chk("MemWData", MemWData, m_wdata);
    end
    chk("IValid", IValid, m_iv);
    chk("DValid", DValid, m_dv);
    chk("IData", IData, m_idata);
    chk("DData", DData, m_ddata);
    chk("Err", Err, m_err);
    chk("StallF", StallF, IReq && !m_iv);
    chk("StallM", StallM, DReq && !m_dv);
  endtask

  // The single compare process: advance the model on each rising edge and
  // check the outputs on the following falling edge.
  initial begin
    @(posedge clk);
    while (!done) begin
      model_step();
      @(negedge clk);
      model_compare();
      @(posedge clk);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  int          n;
  int          mode;
  bit          seen;
  logic [31:0] order [$];

  initial begin
    reset = 1; IReq = 0; DReq = 0; DWe = 0; MemAck = 0;
    IAddr = 0; DAddr = 0; DWData = 0; MemRData = 0;
    repeat (2) cyc();
    reset = 0;

    // Reset state.
    chk("rst_MemReq", MemReq, 0);
    chk("rst_MemWe", MemWe, 0);
    chk("rst_MemAddr", MemAddr, 0);
    chk("rst_IData", IData, 0);
    chk("rst_DData", DData, 0);
    chk("rst_Err", Err, 0);

    // Fetch from 0x100; the acknowledge comes in the second busy cycle.
    IReq = 1; IAddr = 32'h100; n = 0;
    cyc(); if (MemReq) n++;
    chk("f_addr", MemAddr, 32'h100);
    cyc(); if (MemReq) n++;
    MemAck = 1; MemRData = 32'hE3A01005;
    cyc(); if (MemReq) n++;
    MemAck = 0;
    chk("f_busy_cycles", n, 2);
    chk("f_ivalid", IValid, 1);
    chk("f_idata", IData, 32'hE3A01005);
    chk("f_stallf", StallF, 0);
    IReq = 0;
    cyc();
    chk("f_ivalid_once", IValid, 0);

    // Store of 0x12345678 to 0x2000.
    DReq = 1; DWe = 1; DAddr = 32'h2000; DWData = 32'h12345678;
    cyc();
    chk("s_we", MemWe, 1);
    chk("s_addr", MemAddr, 32'h2000);
    chk("s_wdata", MemWData, 32'h12345678);
    MemAck = 1; MemRData = 32'hDEADBEEF;
    cyc();
    MemAck = 0;
    chk("s_dvalid", DValid, 1);
    chk("s_ddata_kept", DData, 0);
    chk("s_stallm", StallM, 0);
    DReq = 0; DWe = 0;
    cyc();
    chk("s_stallm_after", StallM, 0);

    // Fetch address changes while the access is in progress.
    IReq = 1; IAddr = 32'h500;
    cyc();
    IAddr = 32'h504;
    cyc();
    chk("hold_addr", MemAddr, 32'h500);
    MemAck = 1; MemRData = 32'h11;
    cyc();
    MemAck = 0;
    chk("hold_ivalid", IValid, 1);
    chk("hold_idata", IData, 32'h11);
    IReq = 0;
    cyc();

    // Simultaneous requests after reset: I first, then alternation.
    // MemAck is held high, which also exercises acknowledges seen in IDLE.
    do_reset();
    IReq = 1; IAddr = 32'h40; DReq = 1; DWe = 0; DAddr = 32'h80;
    MemAck = 1; MemRData = 32'h5A5A;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (MemReq) order.push_back(MemAddr);
    end
    chk("alt_count", order.size() >= 4, 1);
    if (order.size() >= 4) begin
      chk("alt_0", order[0], 32'h40);
      chk("alt_1", order[1], 32'h80);
      chk("alt_2", order[2], 32'h40);
      chk("alt_3", order[3], 32'h80);
    end
    IReq = 0; DReq = 0;
    repeat (3) cyc();
    MemAck = 0;
    cyc();

    // Load that is never acknowledged: watchdog timeout.
    do_reset();
    DReq = 1; DWe = 0; DAddr = 32'h300; n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (MemReq) n++;
      if (DValid) seen = 1;
    end
    chk("to_pulse_seen", seen, 1);
    chk("to_busy_cycles", n, TO);
    chk("to_ddata", DData, 0);
    chk("to_err", Err, 1);
    chk("to_memreq", MemReq, 0);
    DReq = 0;
    repeat (3) cyc();
    chk("to_err_sticky", Err, 1);

    // Reset in the middle of a fetch.
    do_reset();
    chk("r_err_clear", Err, 0);
    IReq = 1; IAddr = 32'h600;
    cyc();
    chk("r_busy", MemReq, 1);
    reset = 1;
    cyc();
    reset = 0; IReq = 0;
    chk("r_memreq", MemReq, 0);
    chk("r_ivalid", IValid, 0);
    MemAck = 1; MemRData = 32'h77;
    cyc();
    MemAck = 0;
    chk("r_ack_ignored_v", IValid, 0);
    chk("r_ack_ignored_d", IData, 0);
    chk("r_ack_ignored_req", MemReq, 0);
    cyc();

    // Randomized traffic. The acknowledge probability rotates between fast,
    // slow and very slow, so that the timeout path is reached often.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      mode = (c / 250) % 3;
      if (mode == 0)      MemAck = ($urandom_range(0, 1) == 1);
      else if (mode == 1) MemAck = ($urandom_range(0, 7) == 0);
      else                MemAck = ($urandom_range(0, 39) == 0);
      MemRData = $urandom;
      reset = ($urandom_range(0, 599) == 0);

      if (m_owner == 1) begin
        if ($urandom_range(0, 7) == 0) IAddr = $urandom;
      end else if (m_iv) begin
        IReq = $urandom_range(0, 1); IAddr = $urandom;
      end else if (IReq) begin
        if ($urandom_range(0, 15) == 0) IReq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        IReq = 1; IAddr = $urandom;
      end

      if (m_owner == 2) begin
        if ($urandom_range(0, 7) == 0) begin
          DAddr = $urandom; DWData = $urandom;
        end
      end else if (m_dv) begin
        DReq = $urandom_range(0, 1); DWe = $urandom_range(0, 1);
        DAddr = $urandom; DWData = $urandom;
      end else if (DReq) begin
        if ($urandom_range(0, 15) == 0) DReq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        DReq = 1; DWe = $urandom_range(0, 1);
        DAddr = $urandom; DWData = $urandom;
      end
    end

    reset = 0;
    cyc();
    done = 1;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
